// File: rtl/rr_stream_mux.sv
// Stream multiplexer: NCH valid/ready inputs feed one registered output stage.
// The grant comes either from an external select or from a round-robin arbiter.
module rr_stream_mux #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned NCH   = 4,
   parameter int unsigned MODE  = 0,
   localparam int unsigned CW   = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic [CW-1:0]        sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [CW-1:0]        out_chan,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    chan_q, chan_d;
   logic             valid_q, valid_d;
   logic [CW-1:0]    ptr_q, ptr_d;

   logic          ld;
   logic          xfer;
   logic          sel_ok;
   logic          gnt_vld;
   logic [CW-1:0] gnt;
   logic [31:0]   idx;

   assign ld = !valid_q || out_ready;

   // A select wide enough to exceed NCH only exists for non-power-of-two NCH.
   if ((1 << CW) == NCH) begin : g_sel_full
      assign sel_ok = 1'b1;
   end else begin : g_sel_part
      assign sel_ok = (32'(sel) < NCH);
   end

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      if (MODE == 0) begin
         gnt     = sel;
         gnt_vld = sel_ok;
      end else begin
         // Walk downward so the last hit is the first valid channel at or after ptr.
         for (int k = NCH - 1; k >= 0; k--) begin
            idx = (32'(ptr_q) + 32'(k)) % NCH;
            if (in_valid[idx[CW-1:0]]) begin
               gnt     = idx[CW-1:0];
               gnt_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (!rst && ld && gnt_vld) begin
         in_ready[gnt] = 1'b1;
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_comb begin
      data_d  = data_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (ld) begin
         valid_d = xfer;
         if (xfer) begin
            data_d = in_data[32'(gnt)*WIDTH +: WIDTH];
            chan_d = gnt;
            if (MODE == 1) begin
               ptr_d = (gnt == CW'(NCH - 1)) ? '0 : gnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_chan  = chan_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: three instances (select NCH=4, round-robin NCH=4,
// select NCH=3) checked every cycle against a behavioural model plus literal expectations.
module tb_rr_stream_mux;

   logic clk;
   logic rst;

   logic [15:0] ind  [3];
   logic [3:0]  inv  [3];
   logic [1:0]  selv [3];
   logic        ordy [3];
   logic [3:0]  od   [3];
   logic [1:0]  oc   [3];
   logic        ov   [3];
   logic [3:0]  ird0, ird1;
   logic [2:0]  ird2;
   logic [3:0]  ird  [3];

   assign ird[0] = ird0;
   assign ird[1] = ird1;
   assign ird[2] = {1'b0, ird2};

   int nch_of [3] = '{4, 4, 3};
   int mode_of[3] = '{0, 1, 0};
   int exp_a  [4] = '{5, 1, 5, 9};

   // Model state: current output word and arbiter pointer per instance.
   bit mv[3];
   int md[3];
   int mc[3];
   int mp[3];
   bit armed;

   int nchk;
   int npass;

   rr_stream_mux #(.WIDTH(4), .NCH(4), .MODE(0)) u_sel4 (
      .clk(clk), .rst(rst), .in_data(ind[0]), .in_valid(inv[0]), .in_ready(ird0),
      .sel(selv[0]), .out_data(od[0]), .out_chan(oc[0]), .out_valid(ov[0]),
      .out_ready(ordy[0])
   );

   rr_stream_mux #(.WIDTH(4), .NCH(4), .MODE(1)) u_rr4 (
      .clk(clk), .rst(rst), .in_data(ind[1]), .in_valid(inv[1]), .in_ready(ird1),
      .sel(selv[1]), .out_data(od[1]), .out_chan(oc[1]), .out_valid(ov[1]),
      .out_ready(ordy[1])
   );

   rr_stream_mux #(.WIDTH(4), .NCH(3), .MODE(0)) u_sel3 (
      .clk(clk), .rst(rst), .in_data(ind[2][11:0]), .in_valid(inv[2][2:0]), .in_ready(ird2),
      .sel(selv[2]), .out_data(od[2]), .out_chan(oc[2]), .out_valid(ov[2]),
      .out_ready(ordy[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, int act, int exp_v);
      nchk++;
      if (act == exp_v) npass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
   endfunction

   // Granted channel from the rules, or -1 when nothing is granted.
   function automatic int grant(int j);
      if (mode_of[j] == 0) return (int'(selv[j]) < nch_of[j]) ? int'(selv[j]) : -1;
      for (int k = 0; k < nch_of[j]; k++) begin
         int c = (mp[j] + k) % nch_of[j];
         if (inv[j][c]) return c;
      end
      return -1;
   endfunction

   function automatic int exp_rdy(int j);
      if (rst || !(!mv[j] || ordy[j]) || grant(j) < 0) return 0;
      return 1 << grant(j);
   endfunction

   always @(posedge clk) begin
      for (int j = 0; j < 3; j++) begin
         if (rst) begin
            mv[j] <= 1'b0;
            md[j] <= 0;
            mc[j] <= 0;
            mp[j] <= 0;
            armed <= 1'b1;
         end else if (!mv[j] || ordy[j]) begin
            if (grant(j) >= 0 && inv[j][grant(j)]) begin
               mv[j] <= 1'b1;
               md[j] <= int'((ind[j] >> (4 * grant(j))) & 16'hF);
               mc[j] <= grant(j);
               if (mode_of[j] == 1) mp[j] <= (grant(j) + 1) % nch_of[j];
            end else begin
               mv[j] <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int j = 0; j < 3; j++) begin
            chk($sformatf("in_ready[u%0d]", j), int'(ird[j]), exp_rdy(j));
            chk($sformatf("out_valid[u%0d]", j), int'(ov[j]), int'(mv[j]));
            chk($sformatf("out_data[u%0d]", j), int'(od[j]), md[j]);
            chk($sformatf("out_chan[u%0d]", j), int'(oc[j]), mc[j]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nchk  = 0;
      npass = 0;
      armed = 1'b0;
      rst   = 1'b1;
      for (int j = 0; j < 3; j++) begin
         inv[j]  = '0;
         selv[j] = '0;
         ordy[j] = 1'b1;
      end
      ind[0] = 16'h9515;
      ind[1] = 16'hBA98;
      ind[2] = 16'h0321;
      step();
      step();
      chk("reset_valid", int'(ov[0]), 0);
      chk("reset_data", int'(od[1]), 0);
      rst = 1'b0;

      // External select sweep: a=5, b=1, c=5, d=9
      inv[0] = 4'hF;
      for (int s = 0; s < 4; s++) begin
         selv[0] = 2'(s);
         step();
         chk("sel_data", int'(od[0]), exp_a[s]);
         chk("sel_chan", int'(oc[0]), s);
         chk("sel_valid", int'(ov[0]), 1);
      end

      // Backpressure with a select change while held
      ordy[0] = 1'b0;
      selv[0] = 2'd1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_ready", int'(ird[0]), 0);
         chk("bp_data", int'(od[0]), 9);
         chk("bp_chan", int'(oc[0]), 3);
         chk("bp_valid", int'(ov[0]), 1);
      end
      step();
      ordy[0] = 1'b1;
      step();
      chk("bp_next_data", int'(od[0]), 1);
      chk("bp_next_chan", int'(oc[0]), 1);
      inv[0] = '0;
      step();
      chk("idle_valid", int'(ov[0]), 0);
      chk("idle_hold", int'(od[0]), 1);

      // Round-robin with all channels valid
      inv[1] = 4'hF;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("rr_chan", int'(oc[1]), k % 4);
         chk("rr_data", int'(od[1]), 8 + k % 4);
         chk("rr_valid", int'(ov[1]), 1);
      end

      // Mid-stream reset, then only channels 1 and 3 valid
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready", int'(ird[1]), 0);
      step();
      chk("rst_valid", int'(ov[1]), 0);
      chk("rst_data", int'(od[1]), 0);
      chk("rst_chan", int'(oc[1]), 0);
      rst = 1'b0;
      inv[1] = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("alt_chan", int'(oc[1]), (k % 2 == 1) ? 3 : 1);
         chk("alt_data", int'(od[1]), (k % 2 == 1) ? 11 : 9);
      end
      inv[1] = '0;

      // Out-of-range select on NCH=3
      inv[2]  = 4'b0111;
      selv[2] = 2'd2;
      step();
      chk("oor_first_data", int'(od[2]), 3);
      chk("oor_first_chan", int'(oc[2]), 2);
      selv[2] = 2'd3;
      ordy[2] = 1'b0;
      @(negedge clk);
      chk("oor_hold_ready", int'(ird[2]), 0);
      step();
      chk("oor_hold_valid", int'(ov[2]), 1);
      ordy[2] = 1'b1;
      @(negedge clk);
      chk("oor_ready", int'(ird[2]), 0);
      step();
      chk("oor_drained", int'(ov[2]), 0);
      chk("oor_data_hold", int'(od[2]), 3);
      chk("oor_chan_hold", int'(oc[2]), 2);

      step();
      step();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter WIDTH, default 4, data width per channel in bits.
REQ-002 Parameter NCH, default 4, input channel count, range 2..16.
REQ-003 Parameter MODE, default 0: 0 = external select, 1 = round-robin arbitration.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  per-channel valid.
REQ-008 in_ready  output  NCH  per-channel ready; a transfer on channel i occurs when in_valid[i] && in_ready[i].
REQ-009 sel  input  clog2(NCH)  channel select, used only when MODE=0.
REQ-010 out_data  output  WIDTH  registered output data.
REQ-011 out_chan  output  clog2(NCH)  source channel of out_data.
REQ-012 out_valid  output  1  output holds a valid word.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Function
REQ-014 Output stage SHALL be a single register; load enable ld = !out_valid || out_ready.
REQ-015 Grant g (a channel index) SHALL be computed combinationally each cycle; in_ready[i] SHALL be 1 only for i == g and only when ld=1, and 0 on all other channels.
REQ-016 MODE=0: g = sel; if sel >= NCH, no channel SHALL be granted and all in_ready SHALL be 0.
REQ-017 MODE=1: g SHALL be the first channel with in_valid set, searching upward from pointer ptr and wrapping from NCH-1 to 0; if no in_valid is set, there is no grant.
REQ-018 MODE=1: after an accepted input transfer on channel g, ptr SHALL become (g+1) mod NCH; otherwise ptr SHALL hold.
REQ-019 On an input transfer, out_data <= selected channel data, out_chan <= g, out_valid <= 1 at the next edge; latency SHALL be 1 cycle.
REQ-020 If ld=1 and there is no input transfer, out_valid SHALL be cleared to 0; out_data and out_chan SHALL hold.
REQ-021 If ld=0 (out_valid=1, out_ready=0), out_data, out_chan and out_valid SHALL hold, and all in_ready SHALL be 0.
REQ-022 Simultaneous output drain and input transfer in one cycle SHALL sustain full throughput of one word per cycle with no bubble.
REQ-023 No word SHALL be duplicated or dropped; each accepted input SHALL appear exactly once on the output, in acceptance order.
REQ-024 A change of sel while ld=0 SHALL NOT affect the held output word.
REQ-025 in_ready SHALL NOT depend combinationally on in_valid in MODE=0; in MODE=1 the dependence is permitted only through the arbiter.

Reset
REQ-026 While rst=1 at an edge: out_valid <= 0, out_data <= 0, out_chan <= 0, ptr <= 0.
REQ-027 While rst=1, all in_ready SHALL be 0, and no transfer is counted.
REQ-028 Reset asserted mid-stream SHALL discard the held output word; the first grant after reset in MODE=1 SHALL start the search from channel 0.

Verification
REQ-029 MODE=0, WIDTH=4, NCH=4, data a=5, b=1, c=5, d=9, all valid, out_ready=1, sel stepping 0,1,2,3 one per cycle -> out_data 5,1,5,9 with out_chan 0..3, each appearing one cycle after its sel value.
REQ-030 MODE=1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,... and one word per cycle.
REQ-031 MODE=1, only channels 1 and 3 valid -> out_chan alternates 3,1,3,1 after the first grant to 1; channels 0 and 2 never see in_ready=1.
REQ-032 Backpressure: out_ready=0 for 3 cycles with a word held -> out_data, out_chan and out_valid stable and in_ready all 0; out_ready=1 -> the next word follows on the next cycle with no loss.
REQ-033 Reset mid-stream: rst=1 for 1 cycle while out_valid=1 -> out_valid=0, out_data=0 and ptr=0 after the edge; the next grant goes to the lowest valid channel.
REQ-034 MODE=0 with sel=3 on NCH=3 (out of range) -> in_ready all 0 and out_valid drops to 0 after the pending word drains.
